// File: rtl/odd_seq_checker.sv
// Receive-side monitor for an odd-counter stream: locks onto the 1,3,5,... sequence,
// flags deviations while locked and keeps a saturating error count.
module odd_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 2,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clr_err_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [WIDTH-1:0] expected_o
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int               GW      = $clog2(LOCK_CNT + 1);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [GW-1:0]    LOCK_W  = GW'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state, state_next;
    logic [GW-1:0]    good_cnt, good_next, good_inc;
    logic [WIDTH-1:0] expected_next, exp_step;
    logic [ERR_W-1:0] err_cnt_next;
    logic             is_odd, match, err_det;

    assign exp_step = data_i + STEP_W;
    assign good_inc = good_cnt + GW'(1);
    assign is_odd   = data_i[0];
    assign match    = (data_i == expected_o);

    // State register, with the datapath and registered outputs alongside it.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= HUNT;
            good_cnt   <= '0;
            expected_o <= '0;
            locked_o   <= 1'b0;
            err_o      <= 1'b0;
            err_cnt_o  <= '0;
        end else begin
            state      <= state_next;
            good_cnt   <= good_next;
            expected_o <= expected_next;
            locked_o   <= (state_next == LOCKED);
            err_o      <= err_det;
            err_cnt_o  <= err_cnt_next;
        end
    end

    // Next-state logic; idle cycles fall through and hold everything.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        good_next     = good_cnt;
        expected_next = expected_o;
        err_det       = 1'b0;
        if (valid_i) begin
            unique case (state)
                HUNT: begin
                    if (is_odd) begin
                        expected_next = exp_step;
                        good_next     = '0;
                        state_next    = SYNC;
                    end
                end
                SYNC: begin
                    if (match) begin
                        expected_next = exp_step;
                        if (good_inc == LOCK_W) begin
                            good_next  = '0;
                            state_next = LOCKED;
                        end else begin
                            good_next = good_inc;
                        end
                    end else if (is_odd) begin
                        expected_next = exp_step;
                        good_next     = '0;
                    end else begin
                        good_next  = '0;
                        state_next = HUNT;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        expected_next = exp_step;
                    end else begin
                        err_det   = 1'b1;
                        good_next = '0;
                        if (is_odd) begin
                            expected_next = exp_step;
                            state_next    = SYNC;
                        end else begin
                            state_next = HUNT;
                        end
                    end
                end
                default: begin
                    good_next  = '0;
                    state_next = HUNT;
                end
            endcase
        end
    end

    // Output logic: the clear has priority over a same-cycle increment.
    always_comb begin
        err_cnt_next = err_cnt_o;
        if (clr_err_i) begin
            err_cnt_next = '0;
        end else if (err_det && (err_cnt_o != ERR_MAX)) begin
            err_cnt_next = err_cnt_o + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_odd_seq_checker.sv
// Scoreboard bench for odd_seq_checker: a behavioural model pushes expected outputs per
// driven cycle, popped and compared after the clock edge. A second instance uses ERR_W=2.
module tb_odd_seq_checker;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid_i;
    logic [7:0] data_i;
    logic       clr_err_i;

    logic        locked16, err16, locked2, err2;
    logic [15:0] cnt16;
    logic [1:0]  cnt2;
    logic [7:0]  exp16, exp2;

    always #5 clk = ~clk;

    odd_seq_checker #(.WIDTH(8), .STEP(2), .LOCK_CNT(2), .ERR_W(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .data_i(data_i),
        .clr_err_i(clr_err_i), .locked_o(locked16), .err_o(err16),
        .err_cnt_o(cnt16), .expected_o(exp16)
    );

    odd_seq_checker #(.WIDTH(8), .STEP(2), .LOCK_CNT(2), .ERR_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .data_i(data_i),
        .clr_err_i(clr_err_i), .locked_o(locked2), .err_o(err2),
        .err_cnt_o(cnt2), .expected_o(exp2)
    );

    typedef struct packed {
        logic        locked;
        logic        err;
        logic [15:0] cnt16;
        logic [1:0]  cnt2;
        logic [7:0]  expv;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Reference model state: 0=hunt, 1=sync, 2=locked.
    int         m_state;
    int         m_good;
    logic [7:0] m_exp;
    int         m_cnt16;
    int         m_cnt2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_good  = 0;
        m_exp   = 8'd0;
        m_cnt16 = 0;
        m_cnt2  = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic c);
        logic [7:0] nx;
        logic       e;
        sb_t        s;
        nx = d + 8'd2;
        e  = 1'b0;
        if (v) begin
            if (m_state == 0) begin
                if (d[0]) begin m_exp = nx; m_good = 0; m_state = 1; end
            end else if (m_state == 1) begin
                if (d == m_exp) begin
                    m_exp = nx;
                    m_good++;
                    if (m_good == 2) m_state = 2;
                end else if (d[0]) begin
                    m_exp = nx; m_good = 0;
                end else begin
                    m_state = 0;
                end
            end else begin
                if (d == m_exp) begin
                    m_exp = nx;
                end else begin
                    e = 1'b1;
                    if (d[0]) begin m_state = 1; m_good = 0; m_exp = nx; end
                    else m_state = 0;
                end
            end
        end
        if (c) begin
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else if (e) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        s.locked = (m_state == 2);
        s.err    = e;
        s.cnt16  = 16'(m_cnt16);
        s.cnt2   = 2'(m_cnt2);
        s.expv   = m_exp;
        sb_q.push_back(s);
    endtask

    // Drive one cycle at posedge+1, then compare just after the following edge.
    task automatic step(input logic v, input logic [7:0] d, input logic c);
        sb_t s;
        valid_i   = v;
        data_i    = d;
        clr_err_i = c;
        model_step(v, d, c);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            s = sb_q.pop_front();
            check("locked", locked16, s.locked);
            check("err",    err16,    s.err);
            check("cnt16",  cnt16,    s.cnt16);
            check("cnt2",   cnt2,     s.cnt2);
            check("expect", exp16,    s.expv);
        end
    endtask

    task automatic feed(input logic [7:0] d);
        step(1'b1, d, 1'b0);
    endtask

    initial begin
        logic [7:0] src;
        logic       v;
        logic [7:0] d;
        reset_n   = 1'b0;
        valid_i   = 1'b0;
        data_i    = 8'd0;
        clr_err_i = 1'b0;
        model_reset();
        #12;
        check("rst_locked", locked16, 1'b0);
        check("rst_err",    err16,    1'b0);
        check("rst_cnt",    cnt16,    16'd0);
        check("rst_exp",    exp16,    8'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Acquire: 1,3,5 -> locked, expecting 7.
        feed(8'd1); feed(8'd3);
        check("t1_prelock", locked16, 1'b0);
        feed(8'd5);
        check("t1_locked", locked16, 1'b1);
        check("t1_exp",    exp16,    8'd7);

        // Wrap-around is not an error.
        step(1'b0, 8'h00, 1'b0);
        for (int x = 7; x <= 251; x += 2) feed(8'(x));
        feed(8'd253); feed(8'd255); feed(8'd1); feed(8'd3);
        check("t2_locked", locked16, 1'b1);
        check("t2_exp",    exp16,    8'd5);

        // Error while locked, then re-acquire.
        feed(8'd5); feed(8'd7); feed(8'd9);
        feed(8'd12);
        check("t3_errpulse", err16,    1'b1);
        check("t3_cnt",      cnt16,    16'd1);
        check("t3_unlock",   locked16, 1'b0);
        feed(8'd13);
        check("t3_pulse_end", err16, 1'b0);
        feed(8'd15); feed(8'd17);
        check("t3_relock", locked16, 1'b1);

        // Async reset between edges while locked.
        #3 reset_n = 1'b0;
        #1;
        check("t6_locked", locked16, 1'b0);
        check("t6_err",    err16,    1'b0);
        check("t6_cnt",    cnt16,    16'd0);
        check("t6_exp",    exp16,    8'd0);
        #2 reset_n = 1'b1;
        model_reset();
        feed(8'd7);
        check("t6_sync_only", locked16, 1'b0);
        check("t6_seed_exp",  exp16,    8'd9);

        // Idle cycles with junk data in between samples.
        feed(8'd1);
        for (int k = 0; k < 5; k++) step(1'b0, 8'($urandom), 1'b0);
        feed(8'd3);
        step(1'b0, 8'hAA, 1'b0);
        feed(8'd5);
        check("t4_locked", locked16, 1'b1);
        check("t4_noerr",  cnt16,    16'd0);

        // Saturation of the narrow counter, then clear racing an error.
        for (int k = 0; k < 5; k++) begin
            feed(8'd8);
            feed(8'd1); feed(8'd3); feed(8'd5);
        end
        check("t5_sat2",  cnt2,  2'd3);
        check("t5_cnt16", cnt16, 16'd5);
        step(1'b1, 8'd8, 1'b1);
        check("t5_clr_err",  err2, 1'b1);
        check("t5_clr_cnt2", cnt2, 2'd0);
        feed(8'd1); feed(8'd3); feed(8'd5);

        // Random stream with gaps, glitches and occasional clears.
        src = 8'd7;
        for (int k = 0; k < 600; k++) begin
            v = ($urandom_range(0, 3) != 0);
            d = src;
            if ($urandom_range(0, 15) == 0) d = 8'($urandom);
            if (!v) d = 8'($urandom);
            step(v, d, ($urandom_range(0, 31) == 0));
            if (v) src = src + 8'd2;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
